spart_host: RTL and testbench
=============================

Name: spart_host

Overview:
CPU-side initiator for the SPART register bus. It converts byte-stream and configuration handshakes into single-cycle SPART register accesses (iocs_n, iorw_n, ioaddr, databus). It writes TX bytes to DBUF while tx_q_full is low, drains RX bytes from DBUF while rx_q_empty is low, and programs the baud divisor through DBH/DBL. It sits between a processor/stream client and the spart module.

Parameters:
POLL_INTERVAL, 256, idle cycles between status-register reads (used only with the optional feature)
DIV_W, 13, baud divisor width in bits

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
tx_byte_vld  in  1  client has a byte to transmit; held with tx_byte until accepted
tx_byte  in  8  byte to transmit
tx_byte_rdy  out  1  byte accepted; high exactly in the DBUF write cycle
rx_byte_vld  out  1  received byte valid
rx_byte  out  8  received byte
rx_byte_rdy  in  1  client consumes rx_byte
cfg_vld  in  1  divisor update request; held with cfg_divisor until cfg_rdy
cfg_divisor  in  DIV_W  new baud divisor
cfg_rdy  out  1  update accepted; high in the DBL write cycle
status  out  8  last SREG value read: [7:4] TX free entries, [3:0] RX count
iocs_n  out  1  SPART chip select, active low
iorw_n  out  1  1 = read, 0 = write
ioaddr  out  2  spart_ioaddr_t register select
databus  inout  8  driven with write data only when iocs_n=0 and iorw_n=0, otherwise high-Z
tx_q_full  in  1  SPART TX queue full
rx_q_empty  in  1  SPART RX queue empty

Behaviour:
- Reset (synchronous, active-high): state IDLE; iocs_n=1, iorw_n=1, ioaddr=ADDR_DBUF, databus Z; tx_byte_rdy=0, rx_byte_vld=0, rx_byte=0, cfg_rdy=0, status=8'h00; arbitration pointer = RX.
- Bus signals are decoded from the registered state. Each access lasts one clock with iocs_n low. Write data commits at the posedge that ends the cycle. Read data is sampled from databus at the same posedge.
- States:
  - IDLE
  - CFG_HI: write {3'b0,cfg_divisor[12:8]} to ADDR_DBH
  - CFG_LO: write cfg_divisor[7:0] to ADDR_DBL; cfg_rdy=1
  - TX_WR: write tx_byte to ADDR_DBUF; tx_byte_rdy=1
  - RX_RD: read ADDR_DBUF
  - SREG_RD: optional feature only
  - GAP: bus idle one cycle, so SPART flags settle
- IDLE priority:
  - cfg_vld first: CFG_HI -> CFG_LO -> GAP.
  - RX is eligible when !rx_q_empty && !rx_byte_vld.
  - TX is eligible when tx_byte_vld && !tx_q_full.
  - If both are eligible, grant the one not granted last (round-robin), then update the pointer.
- Latency:
  - TX: request seen in IDLE at cycle N -> write in N+1 -> GAP in N+2 -> IDLE in N+3.
  - RX: read in N+1; rx_byte_vld=1 from N+2, held stable until the rx_byte_rdy&&rx_byte_vld handshake, then cleared next cycle.
- Sustained rate is one byte per 3 cycles. While rx_byte_vld is high, no further RX read is issued; this is one-entry backpressure.
- Simultaneous rx_byte_rdy and a new RX read cannot occur, because the read requires rx_byte_vld=0 in IDLE.
- cfg_vld arriving mid-transaction waits for IDLE. A CFG pair is never split by TX/RX.
- tx_q_full high: TX is stalled and tx_byte_rdy stays 0. No write is ever issued while tx_q_full=1.
- Reset mid-access: the bus is released on the next edge and any held rx_byte is discarded.

Optional Feature:
SPART_HOST_STATUS_POLL_EN
- Defined:
  - A counter counts idle IDLE cycles.
  - On reaching POLL_INTERVAL-1 with no other request, SREG_RD reads ADDR_SREG into status, then GAP.
  - The counter restarts on any access.
- Undefined: no SREG_RD state or counter; status is held at 8'h00.

Decomposition:
- MiniLab_defs gains:
  - spart_host_state_t enum
  - SPART_DIV_W=13
  - reuse of the existing spart_ioaddr_t and ADDR_DBUF/ADDR_SREG/ADDR_DBL/ADDR_DBH
- One natural sub-module, spart_host_arb: the two-requester round-robin grant with pointer. Everything else stays in spart_host.

Test Plan:
- Reset, then apply cfg_vld with cfg_divisor=calculate_baud(19200) -> DBH then DBL written in consecutive cycles; SREG/DBH/DBL readback through spart gives the 19200 divisor; cfg_rdy pulses once.
- Send tx_byte=8'hAA with spart connected -> tx_byte_rdy pulses once in the write cycle; the bench UART model receives 8'hAA at 19200 baud.
- Send 8'h55 on RX via the bench UART model -> rx_byte_vld rises; rx_byte=8'h55 held until rx_byte_rdy; exactly one DBUF read is issued.
- Push 9 TX bytes at 921600 baud with a stubbed tx_q_full=1 after 8 -> no bus write while full; the ninth byte is written within 3 cycles of tx_q_full falling.
- RX and TX both eligible for 10 consecutive transactions -> grants strictly alternate; hold rx_byte_rdy=0 -> no further RX reads while TX continues.
- Assert rst during TX_WR -> next cycle iocs_n=1, databus Z, all outputs at reset values; with SPART_HOST_STATUS_POLL_EN defined, idle for POLL_INTERVAL cycles -> SREG read, status=8'h80 when both queues are empty.

Source files
------------

// File: rtl/spart_host_pkg.sv
// Shared SPART register map, host FSM states and divisor width.
package spart_host_pkg;

   localparam int SPART_DIV_W = 13;

   typedef enum logic [1:0] {
      ADDR_DBUF = 2'b00,
      ADDR_SREG = 2'b01,
      ADDR_DBL  = 2'b10,
      ADDR_DBH  = 2'b11
   } spart_ioaddr_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CFG_HI,
      ST_CFG_LO,
      ST_TX_WR,
      ST_RX_RD,
      ST_SREG_RD,
      ST_GAP
   } spart_host_state_t;

endpackage

// File: rtl/spart_host_arb.sv
// Two-requester round-robin grant; last_rx remembers the previous winner.
module spart_host_arb (
   input  logic clk,
   input  logic rst,
   input  logic rx_req,
   input  logic tx_req,
   input  logic take,
   output logic gnt_rx,
   output logic gnt_tx
);

   logic last_rx;

   assign gnt_rx = rx_req && (!tx_req || !last_rx);
   assign gnt_tx = tx_req && (!rx_req || last_rx);

   always_ff @(posedge clk) begin
      if (rst) begin
         last_rx <= 1'b1;
      end else if (take && (gnt_rx || gnt_tx)) begin
         last_rx <= gnt_rx;
      end
   end

endmodule

// File: rtl/spart_host.sv
// CPU-side SPART register bus initiator for TX/RX bytes and divisor setup.
// SPART_HOST_STATUS_POLL_EN adds periodic SREG reads into status.
module spart_host
   import spart_host_pkg::*;
#(
   parameter int POLL_INTERVAL = 256,
   parameter int DIV_W         = SPART_DIV_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tx_byte_vld,
   input  logic [7:0]       tx_byte,
   output logic             tx_byte_rdy,
   output logic             rx_byte_vld,
   output logic [7:0]       rx_byte,
   input  logic             rx_byte_rdy,
   input  logic             cfg_vld,
   input  logic [DIV_W-1:0] cfg_divisor,
   output logic             cfg_rdy,
   output logic [7:0]       status,
   output logic             iocs_n,
   output logic             iorw_n,
   output logic [1:0]       ioaddr,
   inout  wire  [7:0]       databus,
   input  logic             tx_q_full,
   input  logic             rx_q_empty
);

   spart_host_state_t state;
   spart_ioaddr_t     addr;
   logic [7:0]        wdata;
   logic [7:0]        cfg_hi;
   logic              gnt_rx;
   logic              gnt_tx;
   logic              take;

   assign cfg_hi = 8'(cfg_divisor >> 8);
   assign take   = (state == ST_IDLE) && !cfg_vld;

   spart_host_arb u_arb (
      .clk    (clk),
      .rst    (rst),
      .rx_req (!rx_q_empty && !rx_byte_vld),
      .tx_req (tx_byte_vld && !tx_q_full),
      .take   (take),
      .gnt_rx (gnt_rx),
      .gnt_tx (gnt_tx)
   );

   // Bus pins are a pure decode of the registered state.
   always_comb begin
      iocs_n = 1'b1;
      iorw_n = 1'b1;
      addr   = ADDR_DBUF;
      wdata  = tx_byte;
      unique case (state)
         ST_CFG_HI: begin
            iocs_n = 1'b0;
            iorw_n = 1'b0;
            addr   = ADDR_DBH;
            wdata  = cfg_hi;
         end
         ST_CFG_LO: begin
            iocs_n = 1'b0;
            iorw_n = 1'b0;
            addr   = ADDR_DBL;
            wdata  = cfg_divisor[7:0];
         end
         ST_TX_WR: begin
            iocs_n = 1'b0;
            iorw_n = 1'b0;
         end
         ST_RX_RD: begin
            iocs_n = 1'b0;
         end
         ST_SREG_RD: begin
            iocs_n = 1'b0;
            addr   = ADDR_SREG;
         end
         default: ;
      endcase
   end

   assign ioaddr      = addr;
   assign databus     = (!iocs_n && !iorw_n) ? wdata : 8'hzz;
   assign tx_byte_rdy = (state == ST_TX_WR);
   assign cfg_rdy     = (state == ST_CFG_LO);

`ifdef SPART_HOST_STATUS_POLL_EN
   localparam int CW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;

   logic [CW-1:0] poll_cnt;
   logic [7:0]    status_q;
   logic          poll_due;

   assign poll_due = (poll_cnt == CW'(POLL_INTERVAL - 1));
   assign status   = status_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         poll_cnt <= '0;
         status_q <= 8'h00;
      end else begin
         if (take && !gnt_rx && !gnt_tx && !poll_due) begin
            poll_cnt <= poll_cnt + 1'b1;
         end else begin
            poll_cnt <= '0;
         end
         if (state == ST_SREG_RD) begin
            status_q <= databus;
         end
      end
   end
`else
   assign status = 8'h00;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         rx_byte_vld <= 1'b0;
         rx_byte     <= 8'h00;
      end else begin
         if (rx_byte_vld && rx_byte_rdy) begin
            rx_byte_vld <= 1'b0;
         end
         unique case (state)
            ST_IDLE: begin
               if (cfg_vld) begin
                  state <= ST_CFG_HI;
               end else if (gnt_rx) begin
                  state <= ST_RX_RD;
               end else if (gnt_tx) begin
                  state <= ST_TX_WR;
`ifdef SPART_HOST_STATUS_POLL_EN
               end else if (poll_due) begin
                  state <= ST_SREG_RD;
`endif
               end
            end
            ST_CFG_HI: state <= ST_CFG_LO;
            ST_RX_RD: begin
               rx_byte     <= databus;
               rx_byte_vld <= 1'b1;
               state       <= ST_GAP;
            end
            ST_CFG_LO, ST_TX_WR, ST_SREG_RD: state <= ST_GAP;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spart_host.sv
// Self-checking bench: bus-level SPART register model plus scoreboards.
module tb_spart_host;
   import spart_host_pkg::*;

   logic        clk;
   logic        rst;
   logic        tx_byte_vld;
   logic [7:0]  tx_byte;
   logic        tx_byte_rdy;
   logic        rx_byte_vld;
   logic [7:0]  rx_byte;
   logic        rx_byte_rdy;
   logic        cfg_vld;
   logic [12:0] cfg_divisor;
   logic        cfg_rdy;
   logic [7:0]  status;
   logic        iocs_n;
   logic        iorw_n;
   logic [1:0]  ioaddr;
   wire  [7:0]  databus;
   logic        tx_q_full;
   logic        rx_q_empty;

   logic [7:0]  rx_data;
   logic [7:0]  sreg;
   logic [7:0]  dbh;
   logic [7:0]  dbl;
   logic [7:0]  bus_drv;

   int          checks;
   int          errors;
   int          cyc;
   int          rd_cnt;
   int          dbh_cyc;
   int          dbl_cyc;
   logic [10:0] exp_q[$];
   logic [7:0]  rx_exp[$];

   spart_host dut (
      .clk         (clk),
      .rst         (rst),
      .tx_byte_vld (tx_byte_vld),
      .tx_byte     (tx_byte),
      .tx_byte_rdy (tx_byte_rdy),
      .rx_byte_vld (rx_byte_vld),
      .rx_byte     (rx_byte),
      .rx_byte_rdy (rx_byte_rdy),
      .cfg_vld     (cfg_vld),
      .cfg_divisor (cfg_divisor),
      .cfg_rdy     (cfg_rdy),
      .status      (status),
      .iocs_n      (iocs_n),
      .iorw_n      (iorw_n),
      .ioaddr      (ioaddr),
      .databus     (databus),
      .tx_q_full   (tx_q_full),
      .rx_q_empty  (rx_q_empty)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Register model answers reads; 8'h5A marks an undriven bus.
   always_comb begin
      bus_drv = 8'h5A;
      if (!iocs_n && iorw_n) begin
         case (ioaddr)
            ADDR_DBUF: bus_drv = rx_data;
            ADDR_SREG: bus_drv = sreg;
            ADDR_DBL:  bus_drv = dbl;
            default:   bus_drv = dbh;
         endcase
      end
   end

   assign databus = (iocs_n || iorw_n) ? bus_drv : 8'hzz;

   always @(negedge clk) begin
      logic [10:0] got;
      logic [10:0] e;
      logic [7:0]  r;
      if (!rst && !iocs_n) begin
         got = {iorw_n, ioaddr, databus};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL bus_unexpected got=%h", got);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               errors++;
               $display("FAIL bus_access got=%h exp=%h", got, e);
            end
         end
         if (iorw_n && ioaddr == ADDR_DBUF) begin
            rx_exp.push_back(databus);
            rd_cnt++;
         end
         if (!iorw_n) begin
            case (ioaddr)
               ADDR_DBH: begin dbh = databus; dbh_cyc = cyc; end
               ADDR_DBL: begin dbl = databus; dbl_cyc = cyc; end
               ADDR_DBUF: begin
                  checks++;
                  if (tx_q_full) begin
                     errors++;
                     $display("FAIL write_while_full got=1 exp=0");
                  end
               end
               default: ;
            endcase
         end
      end
      if (!rst && rx_byte_vld && rx_byte_rdy) begin
         checks++;
         if (rx_exp.size() == 0) begin
            errors++;
            $display("FAIL rx_unexpected got=%h", rx_byte);
         end else begin
            r = rx_exp.pop_front();
            if (rx_byte !== r) begin
               errors++;
               $display("FAIL rx_byte got=%h exp=%h", rx_byte, r);
            end
         end
      end
   end

   function automatic int calc_baud(input int baud);
      return 50_000_000 / baud;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      checks++;
      if ({iocs_n, iorw_n, ioaddr, tx_byte_rdy, rx_byte_vld,
           rx_byte, cfg_rdy, status} !== {1'b1, 1'b1, 2'b00,
           1'b0, 1'b0, 8'h00, 1'b0, 8'h00}) begin
         errors++;
         $display("FAIL reset_outputs got=%b%b%b%b%b %h %b %h",
                  iocs_n, iorw_n, ioaddr, tx_byte_rdy, rx_byte_vld,
                  rx_byte, cfg_rdy, status);
      end
      checks++;
      if (databus !== 8'h5A) begin
         errors++;
         $display("FAIL reset_databus got=%h exp=5a", databus);
      end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_cfg();
      int div;
      int pulses;
      div = calc_baud(19200);
      pulses = 0;
      exp_q.push_back({1'b0, ADDR_DBH, 8'(div >> 8)});
      exp_q.push_back({1'b0, ADDR_DBL, 8'(div)});
      cfg_divisor = 13'(div);
      cfg_vld = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (cfg_rdy) pulses++;
         tick();
         if (pulses > 0) cfg_vld = 1'b0;
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL cfg_rdy_pulses got=%0d exp=1", pulses);
      end
      checks++;
      if (dbl_cyc != dbh_cyc + 1) begin
         errors++;
         $display("FAIL cfg_consecutive got=%0d exp=%0d", dbl_cyc, dbh_cyc + 1);
      end
      checks++;
      if ({dbh[4:0], dbl} !== 13'(div)) begin
         errors++;
         $display("FAIL cfg_divisor got=%0d exp=%0d", {dbh[4:0], dbl}, div);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL cfg_pending got=%0d exp=0", exp_q.size());
      end
   endtask

   task automatic test_tx();
      int start;
      int acc;
      int pulses;
      pulses = 0;
      acc = -1;
      exp_q.push_back({1'b0, ADDR_DBUF, 8'hAA});
      tx_byte = 8'hAA;
      tx_byte_vld = 1'b1;
      start = cyc;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (tx_byte_rdy) begin
            pulses++;
            acc = cyc;
         end
         tick();
         if (pulses > 0) tx_byte_vld = 1'b0;
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL tx_rdy_pulses got=%0d exp=1", pulses);
      end
      checks++;
      if (acc != start + 1) begin
         errors++;
         $display("FAIL tx_latency got=%0d exp=%0d", acc, start + 1);
      end
   endtask

   task automatic test_rx();
      int start;
      int rd_at;
      int vld_at;
      int base;
      int bad;
      rd_at = -1;
      vld_at = -1;
      bad = 0;
      base = rd_cnt;
      rx_byte_rdy = 1'b0;
      rx_data = 8'h55;
      exp_q.push_back({1'b1, ADDR_DBUF, 8'h55});
      rx_q_empty = 1'b0;
      start = cyc;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (!iocs_n && iorw_n && ioaddr == ADDR_DBUF) rd_at = cyc;
         if (rx_byte_vld && vld_at < 0) vld_at = cyc;
         if (rx_byte_vld && rx_byte !== 8'h55) bad++;
         tick();
         if (rd_at >= 0) rx_q_empty = 1'b1;
      end
      checks++;
      if (rd_at != start + 1) begin
         errors++;
         $display("FAIL rx_read_cycle got=%0d exp=%0d", rd_at, start + 1);
      end
      checks++;
      if (vld_at != start + 2) begin
         errors++;
         $display("FAIL rx_vld_cycle got=%0d exp=%0d", vld_at, start + 2);
      end
      checks++;
      if (!rx_byte_vld || rx_byte !== 8'h55 || bad != 0) begin
         errors++;
         $display("FAIL rx_hold got=%b/%h exp=1/55", rx_byte_vld, rx_byte);
      end
      checks++;
      if (rd_cnt - base != 1) begin
         errors++;
         $display("FAIL rx_read_count got=%0d exp=1", rd_cnt - base);
      end
      rx_byte_rdy = 1'b1;
      tick();
      rx_byte_rdy = 1'b0;
      @(negedge clk);
      checks++;
      if (rx_byte_vld !== 1'b0) begin
         errors++;
         $display("FAIL rx_clear got=%b exp=0", rx_byte_vld);
      end
      tick();
   endtask

   task automatic test_tx_full();
      int rel;
      int acc;
      int stall_bad;
      logic got;
      rel = 0;
      acc = 0;
      stall_bad = 0;
      tx_byte_vld = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tx_byte = 8'h10 + 8'(i);
         exp_q.push_back({1'b0, ADDR_DBUF, tx_byte});
         got = 1'b0;
         if (i == 8) begin
            for (int k = 0; k < 20; k++) begin
               @(negedge clk);
               if (tx_byte_rdy) stall_bad++;
            end
            tick();
            tx_q_full = 1'b0;
            rel = cyc;
         end
         for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (tx_byte_rdy) begin
               got = 1'b1;
               acc = cyc;
            end
         end
         checks++;
         if (!got) begin
            errors++;
            $display("FAIL tx_full_accept byte=%0d got=timeout", i);
         end
         if (i == 7) begin
            #1;
            tx_q_full = 1'b1;
         end
         tick();
      end
      tx_byte_vld = 1'b0;
      checks++;
      if (stall_bad != 0) begin
         errors++;
         $display("FAIL tx_full_stall got=%0d exp=0", stall_bad);
      end
      checks++;
      if (acc - rel < 1 || acc - rel > 3) begin
         errors++;
         $display("FAIL tx_full_resume got=%0d exp=1..3", acc - rel);
      end
   endtask

   task automatic test_arb();
      logic g[$];
      int   alt_bad;
      int   rd2;
      logic txa;
      logic rda;
      alt_bad = 0;
      rd2 = 0;
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back({1'b1, ADDR_DBUF, 8'h80 + 8'(i)});
         exp_q.push_back({1'b0, ADDR_DBUF, 8'h40 + 8'(i)});
      end
      rx_data = 8'h80;
      tx_byte = 8'h40;
      rx_byte_rdy = 1'b1;
      rx_q_empty = 1'b0;
      tx_byte_vld = 1'b1;
      for (int k = 0; k < 60 && exp_q.size() != 0; k++) begin
         @(negedge clk);
         txa = tx_byte_rdy;
         rda = !iocs_n && iorw_n;
         if (!iocs_n) g.push_back(iorw_n);
         tick();
         if (txa) tx_byte++;
         if (rda) rx_data++;
      end
      for (int i = 1; i < g.size(); i++) begin
         if (g[i] == g[i-1]) alt_bad++;
      end
      checks++;
      if (g.size() != 10 || alt_bad != 0) begin
         errors++;
         $display("FAIL arb_alternate got=%0d/%0d exp=10/0", g.size(), alt_bad);
      end
      rx_byte_rdy = 1'b0;
      exp_q.push_back({1'b1, ADDR_DBUF, 8'h85});
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({1'b0, ADDR_DBUF, 8'h45 + 8'(i)});
      end
      for (int k = 0; k < 60 && exp_q.size() != 0; k++) begin
         @(negedge clk);
         txa = tx_byte_rdy;
         rda = !iocs_n && iorw_n;
         if (rda) rd2++;
         tick();
         if (txa) tx_byte++;
         if (rda) rx_data++;
      end
      tx_byte_vld = 1'b0;
      rx_q_empty = 1'b1;
      checks++;
      if (exp_q.size() != 0 || rd2 != 1) begin
         errors++;
         $display("FAIL arb_backpressure got=%0d/%0d exp=0/1", exp_q.size(), rd2);
      end
      checks++;
      if (!rx_byte_vld || rx_byte !== 8'h85) begin
         errors++;
         $display("FAIL arb_rx_held got=%b/%h exp=1/85", rx_byte_vld, rx_byte);
      end
      rx_byte_rdy = 1'b1;
      tick();
      rx_byte_rdy = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_rst_mid();
      logic got;
      got = 1'b0;
      rx_byte_rdy = 1'b0;
      rx_data = 8'hC3;
      exp_q.push_back({1'b1, ADDR_DBUF, 8'hC3});
      rx_q_empty = 1'b0;
      for (int k = 0; k < 10 && !rx_byte_vld; k++) tick();
      rx_q_empty = 1'b1;
      repeat (2) tick();
      exp_q.push_back({1'b0, ADDR_DBUF, 8'h3C});
      tx_byte = 8'h3C;
      tx_byte_vld = 1'b1;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk);
         got = tx_byte_rdy;
      end
      #1;
      rst = 1'b1;
      tx_byte_vld = 1'b0;
      @(negedge clk);
      checks++;
      if (!got || {iocs_n, iorw_n, ioaddr, tx_byte_rdy, rx_byte_vld,
           rx_byte, cfg_rdy, status} !== {1'b1, 1'b1, 2'b00,
           1'b0, 1'b0, 8'h00, 1'b0, 8'h00}) begin
         errors++;
         $display("FAIL rst_mid_outputs got=%b %b%b%b %b %h exp=1 1100 0 00",
                  got, iocs_n, iorw_n, ioaddr, rx_byte_vld, rx_byte);
      end
      checks++;
      if (databus !== 8'h5A) begin
         errors++;
         $display("FAIL rst_mid_databus got=%h exp=5a", databus);
      end
      rx_exp.delete();
      tick();
      rst = 1'b0;
      tick();
   endtask

`ifdef SPART_HOST_STATUS_POLL_EN
   task automatic test_poll();
      sreg = 8'h80;
      exp_q.push_back({1'b1, ADDR_SREG, 8'h80});
      for (int k = 0; k < 300 && status !== 8'h80; k++) tick();
      checks++;
      if (status !== 8'h80 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL poll_status got=%h exp=80", status);
      end
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      cyc = 0;
      rd_cnt = 0;
      dbh_cyc = 0;
      dbl_cyc = 0;
      rst = 1'b1;
      tx_byte_vld = 1'b0;
      tx_byte = 8'h00;
      rx_byte_rdy = 1'b0;
      cfg_vld = 1'b0;
      cfg_divisor = '0;
      tx_q_full = 1'b0;
      rx_q_empty = 1'b1;
      rx_data = 8'h00;
      sreg = 8'h80;
      dbh = 8'h00;
      dbl = 8'h00;
      test_reset();
      test_cfg();
      test_tx();
      test_rx();
      test_tx_full();
      test_arb();
      test_rst_mid();
`ifdef SPART_HOST_STATUS_POLL_EN
      test_poll();
`endif
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL final_pending got=%0d exp=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
